// File: rtl/width_trans_pkg.sv
// Shared types and helpers for the width-conversion FIFO write side.
//   arb_state_e : arbiter state (ST_IDLE / ST_GRANT)
//   clog2_w()   : index/counter width helper, never smaller than 1 bit
package width_trans_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Width needed to hold values 0..n-1, clamped to at least one bit.
  function automatic int clog2_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating find-first: picks the lowest-offset set bit of src_valid,
// starting at rr_ptr and wrapping modulo NUM_REQ. Purely combinational.
//   src_valid  in  NUM_REQ  request vector
//   rr_ptr     in  IW       search start index (< NUM_REQ)
//   sel_idx    out IW       chosen channel (0 when nothing valid)
//   any_valid  out 1        at least one request present
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] src_valid,
  input  logic [IW-1:0]      rr_ptr,
  output logic [IW-1:0]      sel_idx,
  output logic               any_valid
);

  // Scan offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    sel_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (src_valid[(int'(rr_ptr) + k) % NUM_REQ])
        sel_idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
    end
  end

  assign any_valid = |src_valid;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NUM_REQ sources.
// A grant lasts up to BURST_LEN accepted words; FIFO full is the only
// backpressure and stalls the burst without counting against it.
// Ports:
//   clk_wr, rst          write clock, synchronous active-high reset
//   src_valid/src_data   per-channel word offer (channel i at i*WRDATA_SIZE)
//   src_ready            per-channel accept strobe (owner only)
//   full                 FIFO full flag
//   wr_req, wdata        FIFO write port
//   grant, busy          one-hot owner / state is GRANT
//   stat_words           per-channel saturating word counters, only when
//                        FIFO_ARB_STATS_EN is defined
module fifo_wr_arbiter
  import width_trans_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WRDATA_SIZE = 4,
  parameter int BURST_LEN   = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                           clk_wr,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             src_valid,
  input  logic [NUM_REQ*WRDATA_SIZE-1:0] src_data,
  output logic [NUM_REQ-1:0]             src_ready,
  input  logic                           full,
  output logic                           wr_req,
  output logic [WRDATA_SIZE-1:0]         wdata,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_WIDTH-1:0]   stat_words
`endif
);

  localparam int IW = clog2_w(NUM_REQ);
  localparam int BW = clog2_w(BURST_LEN + 1);

  if (NUM_REQ < 2 || NUM_REQ > 16 || BURST_LEN < 1 || WRDATA_SIZE < 1 || CNT_WIDTH < 1) begin : g_bad_param
    $error("fifo_wr_arbiter: illegal parameter set");
  end

  arb_state_e    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BW-1:0] bcnt_q, bcnt_d;

  logic [IW-1:0] pick_idx;
  logic          pick_any;

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .src_valid (src_valid),
    .rr_ptr    (rr_ptr_q),
    .sel_idx   (pick_idx),
    .any_valid (pick_any)
  );

  logic in_grant, own_valid, xfer, burst_done, rel;

  assign in_grant   = (state_q == ST_GRANT);
  assign own_valid  = src_valid[owner_q];
  assign xfer       = in_grant & own_valid & ~full;
  // Limit hit on the accepting cycle, so the last word still goes through.
  assign burst_done = xfer & (bcnt_q == BW'(BURST_LEN - 1));
  // Owner dropping valid releases even while full is stalling the burst.
  assign rel        = in_grant & (~own_valid | burst_done);

  // State register
  always_ff @(posedge clk_wr) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      bcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      bcnt_q   <= bcnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    bcnt_d   = bcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_GRANT;
          owner_d = pick_idx;
          bcnt_d  = '0;
        end
      end
      ST_GRANT: begin
        if (xfer) bcnt_d = bcnt_q + 1'b1;
        if (rel) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        end
      end
    endcase
  end

  // Outputs
  always_comb begin
    wr_req    = xfer;
    busy      = in_grant;
    grant     = '0;
    src_ready = '0;
    wdata     = '0;
    if (in_grant) begin
      grant[owner_q] = 1'b1;
      wdata          = src_data[int'(owner_q)*WRDATA_SIZE +: WRDATA_SIZE];
    end
    if (xfer) src_ready[owner_q] = 1'b1;
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    logic [CNT_WIDTH-1:0] cnt_q;
    always_ff @(posedge clk_wr) begin
      if (rst)
        cnt_q <= '0;
      else if (src_ready[i] && (cnt_q != '1))
        cnt_q <= cnt_q + 1'b1;
    end
    assign stat_words[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int BL = 4;
  localparam int CW = 3;

  logic           clk_wr = 1'b0;
  logic           rst    = 1'b1;
  logic [N-1:0]   src_valid = '0;
  logic [N*W-1:0] src_data  = '0;
  logic [N-1:0]   src_ready;
  logic           full = 1'b0;
  logic           wr_req;
  logic [W-1:0]   wdata;
  logic [N-1:0]   grant;
  logic           busy;
`ifdef FIFO_ARB_STATS_EN
  logic [N*CW-1:0] stat_words;
`endif

  fifo_wr_arbiter #(.NUM_REQ(N), .WRDATA_SIZE(W), .BURST_LEN(BL), .CNT_WIDTH(CW)) dut (
    .clk_wr    (clk_wr),
    .rst       (rst),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .full      (full),
    .wr_req    (wr_req),
    .wdata     (wdata),
    .grant     (grant),
    .busy      (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_words(stat_words)
`endif
  );

  always #5 clk_wr = ~clk_wr;

  typedef struct packed {
    logic [1:0]   ch;
    logic [W-1:0] d;
  } exp_t;

  exp_t expq[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   total[N];
  int   head[N];
  logic full_nx = 1'b0;
  logic rst_nx  = 1'b1;
  logic wr_hist[64];
  int   ncyc;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] word(input int ch, input int idx);
    return W'((ch * 5 + idx) & 15);
  endfunction

  task automatic push(input int ch, input int idx);
    exp_t e;
    e.ch = 2'(ch);
    e.d  = word(ch, idx);
    expq.push_back(e);
  endtask

  // One clock: drive inputs just after the edge, observe on the falling edge.
  task automatic cycle();
    exp_t e;
    @(posedge clk_wr);
    #1;
    rst  = rst_nx;
    full = full_nx;
    for (int i = 0; i < N; i++) begin
      src_valid[i]        = (head[i] < total[i]);
      src_data[i*W +: W]  = word(i, head[i]);
    end
    @(negedge clk_wr);
    ncyc++;
    if (!rst) begin
      wr_hist[ncyc] = wr_req;
      chk("ready_vs_grant", src_ready, wr_req ? grant : '0);
      if (full) chk("no_wr_when_full", wr_req, 0);
      if (wr_req) begin
        if (expq.size() == 0) chk("sb_unexpected_wr", wr_req, 0);
        else begin
          e = expq.pop_front();
          chk("sb_grant", grant, 4'b0001 << e.ch);
          chk("sb_wdata", wdata, e.d);
        end
      end
      for (int i = 0; i < N; i++) if (src_ready[i]) head[i]++;
    end
  endtask

  task automatic do_reset();
    rst_nx  = 1'b1;
    full_nx = 1'b0;
    for (int i = 0; i < N; i++) begin total[i] = 0; head[i] = 0; end
    cycle();
    cycle();
    chk("rst_wr_req", wr_req, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_src_ready", src_ready, 0);
    chk("rst_wdata", wdata, 0);
`ifdef FIFO_ARB_STATS_EN
    chk("rst_stats", stat_words, 0);
`endif
    rst_nx = 1'b0;
    ncyc   = 0;
    for (int i = 0; i < 64; i++) wr_hist[i] = 1'b0;
  endtask

  task automatic hist_chk(input string tag, input logic [31:0] pat, input int len);
    for (int c = 1; c <= len; c++) chk(tag, wr_hist[c], pat[len-c]);
  endtask

  task automatic drain_chk();
    chk("sb_drained", expq.size(), 0);
  endtask

  initial begin
    // Single channel: 4 words, bubble, regrant, 2 words.
    do_reset();
    total[2] = 6;
    for (int k = 0; k < 6; k++) push(2, k);
    for (int c = 0; c < 6; c++) cycle();
    chk("t1_rr_ptr", dut.rr_ptr_q, 3);
    cycle();
    chk("t1_regrant", grant, 4'b0100);
    for (int c = 0; c < 3; c++) cycle();
    hist_chk("t1_wr_pattern", 32'b011110110, 9);
    drain_chk();

    // All four channels: order 0,1,2,3,0 with a bubble between bursts.
    do_reset();
    total[0] = 8; total[1] = 4; total[2] = 4; total[3] = 4;
    for (int b = 0; b < 5; b++)
      for (int k = 0; k < 4; k++) push(b % 4, (b == 4) ? 4 + k : k);
    for (int c = 0; c < 26; c++) cycle();
    for (int c = 1; c <= 26; c++)
      chk("t2_wr_pattern", wr_hist[c], (c >= 2) && (((c - 2) % 5) != 4));
    drain_chk();

    // Full for 3 cycles after the second word.
    do_reset();
    total[1] = 4;
    for (int k = 0; k < 4; k++) push(1, k);
    cycle(); cycle(); cycle();
    full_nx = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("t3_grant_held", grant, 4'b0010);
      chk("t3_busy", busy, 1);
    end
    full_nx = 1'b0;
    for (int c = 0; c < 4; c++) cycle();
    hist_chk("t3_wr_pattern", 32'b0110001100, 10);
    chk("t3_words", head[1], 4);
    drain_chk();

    // Owner drops valid after one word.
    do_reset();
    total[0] = 1; total[2] = 2;
    push(0, 0); push(2, 0); push(2, 1);
    for (int c = 0; c < 4; c++) cycle();
    cycle();
    chk("t4_next_grant", grant, 4'b0100);
    for (int c = 0; c < 2; c++) cycle();
    hist_chk("t4_wr_pattern", 32'b0100110, 7);
    drain_chk();

    // Reset mid-burst, then ch0 and ch3 both valid.
    do_reset();
    total[3] = 4;
    push(3, 0); push(3, 1); push(0, 0); push(3, 2); push(3, 3);
    cycle(); cycle(); cycle();
    rst_nx = 1'b1;
    cycle();
    rst_nx = 1'b0;
    total[0] = 1;
    cycle();
    chk("t5_wr_req", wr_req, 0);
    chk("t5_grant", grant, 0);
    chk("t5_busy", busy, 0);
    chk("t5_src_ready", src_ready, 0);
    chk("t5_wdata", wdata, 0);
    chk("t5_ch3_left", head[3], 2);
    cycle();
    chk("t5_grant_ch0", grant, 4'b0001);
    for (int c = 0; c < 6; c++) cycle();
    drain_chk();

`ifdef FIFO_ARB_STATS_EN
    // Saturating counters.
    do_reset();
    total[1] = 10;
    for (int k = 0; k < 10; k++) push(1, k);
    for (int c = 0; c < 16; c++) cycle();
    chk("t6_stat1", stat_words[1*CW +: CW], 7);
    chk("t6_stat0", stat_words[0*CW +: CW], 0);
    chk("t6_stat2", stat_words[2*CW +: CW], 0);
    chk("t6_stat3", stat_words[3*CW +: CW], 0);
    drain_chk();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
